// File: rtl/lag_measure_pkg.sv
// lag_measure_pkg: channel state type and shared constants for the lag measurement block
package lag_measure_pkg;
    typedef enum logic [1:0] {IDLE, MEASURING, DONE} chan_state_t;
    localparam int DEFAULT_DIVIDER = 27;
    localparam int DEFAULT_TIMEOUT = 500000;
    function automatic logic [63:0] min_init(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction
endpackage

// File: rtl/lag_channel.sv
// lag_channel: one sensor's synchroniser, edge detect, measurement FSM and statistics
// Ports: clock/reset; start/clear_stats pulses; raw sensor pin; shared tick_count;
// last/min/max/avg statistics, result_valid pulse, sticky timeout, done, sensor_level.
module lag_channel
    import lag_measure_pkg::*;
#(
    parameter int COUNT_WIDTH = 20,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT,
    parameter int AVG_LOG2 = 3,
    parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic clear_stats,
    input  logic sensor,
    input  logic [COUNT_WIDTH-1:0] tick_count,
    output logic [COUNT_WIDTH-1:0] last_count,
    output logic [COUNT_WIDTH-1:0] min_count,
    output logic [COUNT_WIDTH-1:0] max_count,
    output logic [COUNT_WIDTH-1:0] avg_count,
    output logic result_valid,
    output logic timeout,
    output logic done,
    output logic sensor_level
);
    localparam int AW = COUNT_WIDTH + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam logic [COUNT_WIDTH-1:0] MIN_INIT = COUNT_WIDTH'(min_init(COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_AT = COUNT_WIDTH'(TIMEOUT_TICKS);
    chan_state_t state;
    logic [1:0] sync;
    logic prev, rise, measuring, capture, timed_out, block_full;
    logic [AW-1:0] acc, acc_next;
    logic [SW-1:0] samples, samples_next;
    // synchroniser resets to the idle pin level so sensor_level starts low
    assign sensor_level = sync[1] ^ SENSOR_ACTIVE_LOW;
    assign rise = sensor_level & ~prev;
    // a start in the same cycle restarts the measurement and discards any edge/timeout
    assign measuring = (state == MEASURING) && !start;
    assign capture = measuring && rise;
    assign timed_out = measuring && !rise && (tick_count == TIMEOUT_AT);
    assign acc_next = acc + AW'(tick_count);
    assign samples_next = samples + SW'(1);
    assign block_full = samples_next == SW'(1 << AVG_LOG2);
    assign done = state == DONE;
    always_ff @(posedge clock) begin
        if (reset) begin
            sync <= {2{SENSOR_ACTIVE_LOW}};
            prev <= 1'b0;
            state <= IDLE;
            last_count <= '0;
            min_count <= MIN_INIT;
            max_count <= '0;
            avg_count <= '0;
            acc <= '0;
            samples <= '0;
            result_valid <= 1'b0;
            timeout <= 1'b0;
        end else begin
            sync <= {sync[0], sensor};
            prev <= sensor_level;
            result_valid <= capture && !clear_stats;
            if (start) begin
                state <= MEASURING;
                timeout <= 1'b0;
            end else if (capture || timed_out) begin
                state <= DONE;
            end
            if (timed_out) timeout <= 1'b1;
            if (clear_stats) begin
                last_count <= '0;
                min_count <= MIN_INIT;
                max_count <= '0;
                avg_count <= '0;
                acc <= '0;
                samples <= '0;
            end else if (capture) begin
                last_count <= tick_count;
                if (tick_count < min_count) min_count <= tick_count;
                if (tick_count > max_count) max_count <= tick_count;
                acc <= block_full ? '0 : acc_next;
                samples <= block_full ? '0 : samples_next;
                if (block_full) avg_count <= COUNT_WIDTH'(acc_next >> AVG_LOG2);
            end
        end
    end
endmodule

// File: rtl/lag_measure_multi.sv
// lag_measure_multi: multi-channel start-to-sensor lag timer with per-channel statistics
// Ports: clock/reset; start and clear_stats pulses; raw sensor pins; packed per-channel
// last/min/max/avg counts (channel i at [i*COUNT_WIDTH +: COUNT_WIDTH]); result_valid,
// timeout and sensor_level per channel; all_done when every channel has finished.
module lag_measure_multi
    import lag_measure_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int CLOCK_DIVIDER = DEFAULT_DIVIDER,
    parameter int COUNT_WIDTH = 20,
    parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT,
    parameter int AVG_LOG2 = 3,
    parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic clear_stats,
    input  logic [CHANNELS-1:0] sensor,
    output logic [CHANNELS*COUNT_WIDTH-1:0] last_count,
    output logic [CHANNELS*COUNT_WIDTH-1:0] min_count,
    output logic [CHANNELS*COUNT_WIDTH-1:0] max_count,
    output logic [CHANNELS*COUNT_WIDTH-1:0] avg_count,
    output logic [CHANNELS-1:0] result_valid,
    output logic [CHANNELS-1:0] timeout,
    output logic all_done,
    output logic [CHANNELS-1:0] sensor_level
);
    localparam int PW = $clog2(CLOCK_DIVIDER + 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_AT = COUNT_WIDTH'(TIMEOUT_TICKS);
    logic [PW-1:0] prescaler;
    logic [COUNT_WIDTH-1:0] tick_count;
    logic [CHANNELS-1:0] done;
    logic tick;
    assign tick = prescaler == PW'(CLOCK_DIVIDER - 1);
    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler <= '0;
            tick_count <= '0;
            all_done <= 1'b0;
        end else begin
            all_done <= &done;
            if (start) begin
                prescaler <= '0;
                tick_count <= '0;
            end else begin
                prescaler <= tick ? '0 : prescaler + 1'b1;
                if (tick && tick_count != TIMEOUT_AT) tick_count <= tick_count + 1'b1;
            end
        end
    end
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        lag_channel #(
            .COUNT_WIDTH(COUNT_WIDTH),
            .TIMEOUT_TICKS(TIMEOUT_TICKS),
            .AVG_LOG2(AVG_LOG2),
            .SENSOR_ACTIVE_LOW(SENSOR_ACTIVE_LOW)
        ) u_ch (
            .clock(clock),
            .reset(reset),
            .start(start),
            .clear_stats(clear_stats),
            .sensor(sensor[i]),
            .tick_count(tick_count),
            .last_count(last_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .min_count(min_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .max_count(max_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .avg_count(avg_count[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .result_valid(result_valid[i]),
            .timeout(timeout[i]),
            .done(done[i]),
            .sensor_level(sensor_level[i])
        );
    end
endmodule
